cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run/step/breakpoint controller for the single-cycle CPU. It turns the slow divider tick into a one-cycle CPU enable pulse, `cpu_en_o`, and gates that pulse by operating mode: free run, halt, single step, or stop at a PC breakpoint. The PC register, RF write and DM write all update on `clk` only when `cpu_en_o` is high. This replaces the divided-clock PC stepping with a single clock domain plus enable, and adds a retired-instruction counter for the debug display.

## Interface
- `PC_W`, default 6, width of the PC / ROM address.
- `CNT_W`, default 32, width of the retired-instruction counter.
- `DEB_CYCLES`, default 20'd1_000_000, number of stable `clk` cycles the step button must hold before it counts as a press.

- `clk`, in, 1, system clock.
- `rstn`, in, 1, asynchronous, active-low reset.
- `tick_i`, in, 1, one-`clk` pulse from the clock divider; sets the CPU execution rate.
- `run_sw_i`, in, 1, raw switch level: 1 requests RUN, 0 requests HALT.
- `step_btn_i`, in, 1, raw, undebounced single-step button.
- `bp_en_i`, in, 1, breakpoint enable.
- `bp_addr_i`, in, `PC_W`, breakpoint PC.
- `pc_i`, in, `PC_W`, current PC, i.e. the address of the instruction about to execute.
- `cpu_en_o`, out, 1, one-cycle commit enable for PC, RF and DM.
- `state_o`, out, 2, current state: HALT=00, RUN=01, STEP=10, BREAK=11.
- `halted_o`, out, 1, high in HALT or BREAK.
- `bp_hit_o`, out, 1, high while in BREAK.
- `instr_cnt_o`, out, `CNT_W`, count of `cpu_en_o` pulses issued.

## Operation
- **Input conditioning**
  - `run_sw_i` and `step_btn_i` each pass through a 2-FF synchronizer.
  - The synchronized button goes through the debouncer. The rising edge of the debounced level produces `step_pulse`, one cycle wide.
- **`bp_match`** = `bp_en_i && pc_i == bp_addr_i && !bp_skip`.
- **HALT**
  - run_sync=1 → RUN, and set `bp_skip`.
  - Otherwise `step_pulse` → STEP.
  - `tick_i` is ignored.
- **RUN**
  - run_sync=0 → HALT. This has priority over a same-cycle `tick_i`, so no enable is issued.
  - Else, `tick_i` with `bp_match` → BREAK, no enable.
  - Else, `tick_i` → issue enable, clear `bp_skip`.
  - `step_pulse` is ignored.
- **STEP**
  - The next `tick_i` issues an enable and moves to HALT. Breakpoints are ignored in STEP.
  - run_sync=1 has no effect until the state is back in HALT.
  - `step_pulse` is ignored.
- **BREAK**
  - run_sync=0 → HALT.
  - `step_pulse` → STEP. The breakpointed instruction executes on the next tick.
  - Leaving BREAK via HALT→RUN sets `bp_skip`, so the resumed run executes the breakpointed instruction instead of re-breaking.
- **`bp_skip`**
  - Set on every HALT→RUN transition.
  - Cleared on the first enable issued in RUN.
  - Reset value 0.
- **`instr_cnt_o`** increments by 1 on each `cpu_en_o` pulse and wraps modulo 2^`CNT_W`.
- **Debouncer**
  - The output level follows the input after it has been stable for `DEB_CYCLES` consecutive cycles.
  - Any change in the input reloads the counter.

## Timing
- Reset values:
  - state HALT; `cpu_en_o`=0, `state_o`=00, `halted_o`=1, `bp_hit_o`=0, `instr_cnt_o`=0.
  - `bp_skip`=0; synchronizers 0; debounced level 0; debounce counter 0.
- `cpu_en_o` is registered: it is high exactly one cycle, in the cycle after the qualifying `tick_i`. There is never more than one pulse per tick.
- A state change becomes visible on `state_o`, `halted_o` and `bp_hit_o` in the cycle after the deciding input, from a registered state.
- `bp_match` samples `pc_i` in the same cycle as `tick_i`.
- `instr_cnt_o` updates in the same cycle `cpu_en_o` is high, so the new value is visible the following cycle.
- Step latency: button stable → `step_pulse` takes 2 sync + `DEB_CYCLES` + 1 cycles. Then STEP is entered one cycle later, and `cpu_en_o` follows one cycle after the next `tick_i`.
- Reset asserted mid-operation: everything returns to reset values immediately, and an in-flight `cpu_en_o` is dropped.

## Structure
- A shared package holds the state encoding localparams (`ST_HALT`, `ST_RUN`, `ST_STEP`, `ST_BREAK`) and the default `DEB_CYCLES`.
- One sub-module, `btn_debounce` (synchronizer + stable counter + rising-edge pulse), parameterised by `DEB_CYCLES`. It is reused later for the other board buttons.
- The FSM, `bp_skip` flag, enable register and counter live in `cpu_run_ctrl`.

## Test plan
All scenarios use `DEB_CYCLES`=4 and `tick_i` every 10 cycles.

1. **Reset:** `rstn`=0 with `tick_i` toggling → `cpu_en_o`=0, `state_o`=00, `halted_o`=1, `instr_cnt_o`=0 throughout.
2. **Free run:** set `run_sw_i`=1, `bp_en_i`=0, run 5 ticks → exactly 5 `cpu_en_o` pulses, each one cycle after its tick; `instr_cnt_o`=5.
3. **Breakpoint and resume:**
   - `bp_addr_i`=3, `bp_en_i`=1, `pc_i` driven 0,1,2,3 by a model PC → 3 enables, then `state_o`=11 and `bp_hit_o`=1, with no enable at pc=3.
   - Toggle `run_sw_i` 0 then 1 → the next tick issues an enable at pc=3, with no re-break.
4. **Single step:**
   - In HALT, hold `step_btn_i` with glitches shorter than 4 cycles → no step.
   - Hold stable for 8 cycles → exactly one `cpu_en_o` at the next tick, then back to HALT; `instr_cnt_o` +1.
5. **Simultaneous events:**
   - `run_sw` falling synchronized in the same cycle as `tick_i` in RUN → HALT with no enable.
   - `step_pulse` during RUN → ignored.
6. **Reset mid-step and wrap:**
   - Assert `rstn` while in STEP before its tick → HALT, no enable.
   - With `CNT_W`=4, 16 enables → `instr_cnt_o` wraps to 0.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: shared state encoding and default debounce length for the run controller
package cpu_run_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;
  localparam logic [19:0] DEB_CYCLES_DEF = 20'd1_000_000;
endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability filter and one-cycle rising-edge pulse for a raw button
module btn_debounce
  import cpu_run_ctrl_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_i,
  output logic pulse_o
);
  logic [1:0] sync;
  logic level, level_q;
  logic [19:0] cnt;
  // the counter only runs while the synced input disagrees with the level, so any bounce restarts it
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      pulse_o <= 1'b0;
    end else begin
      sync    <= {sync[0], btn_i};
      level_q <= level;
      pulse_o <= level & ~level_q;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == DEB_CYCLES - 20'd1) begin
        level <= sync[1];
        cnt   <= '0;
      end else cnt <= cnt + 20'd1;
    end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt/step/breakpoint FSM turning divider ticks into a one-cycle CPU commit enable
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int          PC_W       = 6,
  parameter int          CNT_W      = 32,
  parameter logic [19:0] DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tick_i,
  input  logic             run_sw_i,
  input  logic             step_btn_i,
  input  logic             bp_en_i,
  input  logic [PC_W-1:0]  bp_addr_i,
  input  logic [PC_W-1:0]  pc_i,
  output logic             cpu_en_o,
  output logic [1:0]       state_o,
  output logic             halted_o,
  output logic             bp_hit_o,
  output logic [CNT_W-1:0] instr_cnt_o
);
  state_t state;
  logic [1:0] run_sync;
  logic run_s, step_pulse, bp_skip, bp_match;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (
    .clk    (clk),
    .rstn   (rstn),
    .btn_i  (step_btn_i),
    .pulse_o(step_pulse)
  );
  assign run_s    = run_sync[1];
  assign bp_match = bp_en_i && pc_i == bp_addr_i && !bp_skip;
  assign state_o  = state;
  assign halted_o = state == ST_HALT || state == ST_BREAK;
  assign bp_hit_o = state == ST_BREAK;
  // bp_skip lets a resumed run execute the instruction it broke on instead of re-breaking
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      run_sync    <= '0;
      state       <= ST_HALT;
      cpu_en_o    <= 1'b0;
      bp_skip     <= 1'b0;
      instr_cnt_o <= '0;
    end else begin
      run_sync <= {run_sync[0], run_sw_i};
      cpu_en_o <= 1'b0;
      if (cpu_en_o) instr_cnt_o <= instr_cnt_o + CNT_W'(1);
      case (state)
        ST_HALT:
          if (run_s) begin
            state   <= ST_RUN;
            bp_skip <= 1'b1;
          end else if (step_pulse) state <= ST_STEP;
        ST_RUN:
          if (!run_s) state <= ST_HALT;
          else if (tick_i && bp_match) state <= ST_BREAK;
          else if (tick_i) begin
            cpu_en_o <= 1'b1;
            bp_skip  <= 1'b0;
          end
        ST_STEP:
          if (tick_i) begin
            cpu_en_o <= 1'b1;
            state    <= ST_HALT;
          end
        default:
          if (!run_s) state <= ST_HALT;
          else if (step_pulse) state <= ST_STEP;
      endcase
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed checks of run, breakpoint, step, priority, reset and counter wrap
module tb_cpu_run_ctrl;
  logic clk = 1'b0, rstn = 1'b0, tick_i = 1'b0, run_sw_i = 1'b0, step_btn_i = 1'b0, bp_en_i = 1'b0;
  logic [5:0] bp_addr_i = '0, pc_i;
  logic cpu_en_o, halted_o, bp_hit_o;
  logic [1:0] state_o;
  logic [3:0] instr_cnt_o;
  int errors = 0, checks = 0, pulses, first, total;

  cpu_run_ctrl #(.PC_W(6), .CNT_W(4), .DEB_CYCLES(20'd4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .tick_i     (tick_i),
    .run_sw_i   (run_sw_i),
    .step_btn_i (step_btn_i),
    .bp_en_i    (bp_en_i),
    .bp_addr_i  (bp_addr_i),
    .pc_i       (pc_i),
    .cpu_en_o   (cpu_en_o),
    .state_o    (state_o),
    .halted_o   (halted_o),
    .bp_hit_o   (bp_hit_o),
    .instr_cnt_o(instr_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn)
    if (!rstn) pc_i <= '0;
    else if (cpu_en_o) pc_i <= pc_i + 6'd1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_tick(output int p, output int f);
    p = 0;
    f = -1;
    for (int i = 0; i < 10; i++) begin
      tick_i = (i == 0);
      @(negedge clk);
      if (cpu_en_o) begin
        p++;
        if (f < 0) f = i;
      end
    end
    tick_i = 1'b0;
  endtask

  task automatic press(input int n);
    step_btn_i = 1'b1;
    cyc(n);
    step_btn_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      tick_i = i[0];
      @(negedge clk);
      check("rst_en", 32'(cpu_en_o), 0);
      check("rst_state", 32'(state_o), 0);
      check("rst_halted", 32'(halted_o), 1);
      check("rst_cnt", 32'(instr_cnt_o), 0);
    end
    tick_i = 1'b0;
    rstn = 1'b1;
    cyc(2);

    run_sw_i = 1'b1;
    cyc(5);
    check("run_state", 32'(state_o), 1);
    for (int i = 0; i < 5; i++) begin
      run_tick(pulses, first);
      check("run_pulses", pulses, 1);
      check("run_latency", first, 0);
    end
    check("run_cnt", 32'(instr_cnt_o), 5);

    rstn = 1'b0;
    cyc(2);
    rstn = 1'b1;
    bp_addr_i = 6'd3;
    bp_en_i = 1'b1;
    cyc(5);
    total = 0;
    for (int i = 0; i < 3; i++) begin
      run_tick(pulses, first);
      total += pulses;
    end
    check("bp_pre_pulses", total, 3);
    run_tick(pulses, first);
    check("bp_hit_pulses", pulses, 0);
    check("bp_state", 32'(state_o), 3);
    check("bp_hit", 32'(bp_hit_o), 1);
    check("bp_halted", 32'(halted_o), 1);
    check("bp_pc", 32'(pc_i), 3);
    check("bp_cnt", 32'(instr_cnt_o), 3);
    run_sw_i = 1'b0;
    cyc(5);
    check("bp_to_halt", 32'(state_o), 0);
    run_sw_i = 1'b1;
    cyc(5);
    check("bp_resume_state", 32'(state_o), 1);
    run_tick(pulses, first);
    check("bp_resume_pulses", pulses, 1);
    check("bp_resume_pc", 32'(pc_i), 4);
    check("bp_no_rebreak", 32'(state_o), 1);

    run_sw_i = 1'b0;
    cyc(5);
    check("halt_state", 32'(state_o), 0);
    for (int i = 0; i < 3; i++) begin
      press(3);
      cyc(2);
    end
    cyc(10);
    check("glitch_state", 32'(state_o), 0);
    run_tick(pulses, first);
    check("glitch_pulses", pulses, 0);
    press(8);
    check("step_state", 32'(state_o), 2);
    run_tick(pulses, first);
    check("step_pulses", pulses, 1);
    check("step_latency", first, 0);
    check("step_back_halt", 32'(state_o), 0);
    check("step_cnt", 32'(instr_cnt_o), 5);
    run_tick(pulses, first);
    check("step_once", pulses, 0);

    bp_en_i = 1'b0;
    run_sw_i = 1'b1;
    cyc(5);
    check("sim_run", 32'(state_o), 1);
    run_sw_i = 1'b0;
    cyc(2);
    run_tick(pulses, first);
    check("sim_stop_pulses", pulses, 0);
    check("sim_stop_state", 32'(state_o), 0);
    check("sim_stop_cnt", 32'(instr_cnt_o), 5);
    run_sw_i = 1'b1;
    cyc(5);
    press(8);
    cyc(4);
    check("run_ign_step", 32'(state_o), 1);
    run_tick(pulses, first);
    check("run_ign_pulses", pulses, 1);
    check("run_ign_cnt", 32'(instr_cnt_o), 6);

    run_sw_i = 1'b0;
    cyc(5);
    press(8);
    check("rst_step_state", 32'(state_o), 2);
    rstn = 1'b0;
    tick_i = 1'b1;
    @(negedge clk);
    check("rst_step_en", 32'(cpu_en_o), 0);
    check("rst_step_halt", 32'(state_o), 0);
    check("rst_step_cnt", 32'(instr_cnt_o), 0);
    tick_i = 1'b0;
    rstn = 1'b1;
    cyc(2);
    run_tick(pulses, first);
    check("rst_step_after", pulses, 0);

    run_sw_i = 1'b1;
    cyc(5);
    total = 0;
    for (int i = 0; i < 15; i++) begin
      run_tick(pulses, first);
      total += pulses;
    end
    check("wrap_cnt15", 32'(instr_cnt_o), 15);
    run_tick(pulses, first);
    total += pulses;
    check("wrap_total", total, 16);
    check("wrap_cnt0", 32'(instr_cnt_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
